i2c_slave_regif: RTL and testbench

//  I2C target (slave) endpoint: responds to a 7-bit device address and bridges
//  I2C frames onto a simple 8-bit register-file port (8-bit reg addr, 8-bit data).
//  It is the responder for i2c_master and serves as its bench model and on-chip target.

---
 rtl/i2c_slave_regif.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target endpoint bridging 7-bit-addressed I2C frames onto an 8-bit register-file port.
// Supports pointer write, burst write, combined-format read and sequential read; never stretches SCL.
module i2c_slave_regif #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] o_reg_addr,
    output logic       o_wr_en,
    output logic [7:0] o_wdata,
    output logic       o_rd_en,
    input  logic [7:0] i_rdata,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_REG,
        ST_ACK_R,
        ST_WDATA,
        ST_ACK_W,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;
    logic                   fallDly_q;

    state_t     state_q;
    logic [2:0] bitCnt_q;
    logic [7:0] shift_q;
    logic [7:0] ptr_q;
    logic [7:0] wdata_q;
    logic       wrEn_q;
    logic       rdEn_q;
    logic       ptrInc_q;
    logic       drive_q;
    logic       busy_q;
    logic       rw_q;

    logic       sclNow;
    logic       sdaNow;
    logic       sclRise;
    logic       startCond;
    logic       stopCond;
    logic [7:0] rxByte;

    // Reset gates the driver combinationally so the bus is freed in the reset cycle itself.
    assign SDA = (drive_q && !i_rst) ? 1'b0 : 1'bz;

    assign sclNow    = sclSync_q[SYNC_STAGES-1];
    assign sdaNow    = sdaSync_q[SYNC_STAGES-1];
    assign sclRise   = sclNow & ~sclPrev_q;
    assign startCond = sclNow & sclPrev_q & sdaPrev_q & ~sdaNow;
    assign stopCond  = sclNow & sclPrev_q & ~sdaPrev_q & sdaNow;
    assign rxByte    = {shift_q[6:0], sdaNow};

    assign o_reg_addr = ptr_q;
    assign o_wr_en    = wrEn_q;
    assign o_wdata    = wdata_q;
    assign o_rd_en    = rdEn_q;
    assign o_busy     = busy_q;

    // Synchronizers idle high so that leaving reset on a quiet bus produces no false edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
            fallDly_q <= 1'b0;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], SCL};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], SDA};
            sclPrev_q <= sclNow;
            sdaPrev_q <= sdaNow;
            fallDly_q <= ~sclNow & sclPrev_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'h00;
            ptr_q    <= 8'h00;
            wdata_q  <= 8'h00;
            wrEn_q   <= 1'b0;
            rdEn_q   <= 1'b0;
            ptrInc_q <= 1'b0;
            drive_q  <= 1'b0;
            busy_q   <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            wrEn_q   <= 1'b0;
            rdEn_q   <= 1'b0;
            ptrInc_q <= 1'b0;
            if (ptrInc_q) begin
                ptr_q <= ptr_q + 8'd1;
            end
            if (rdEn_q) begin
                shift_q <= i_rdata;
            end

            if (startCond) begin
                state_q  <= ST_ADDR;
                bitCnt_q <= 3'd0;
                drive_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stopCond) begin
                state_q <= ST_IDLE;
                drive_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (sclRise) begin
                            shift_q <= rxByte;
                            if (bitCnt_q == 3'd7) begin
                                bitCnt_q <= 3'd0;
                                if (rxByte[7:1] == SLAVE_ADDR) begin
                                    state_q <= ST_ACK_A;
                                    rw_q    <= rxByte[0];
                                    rdEn_q  <= rxByte[0];
                                    busy_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_WAIT;
                                end
                            end else begin
                                bitCnt_q <= bitCnt_q + 3'd1;
                            end
                        end
                    end
                    // First fall after the 8th bit pulls SDA low; the next fall ends the ACK clock.
                    ST_ACK_A, ST_ACK_R, ST_ACK_W: begin
                        if (fallDly_q) begin
                            if (!drive_q) begin
                                drive_q <= 1'b1;
                            end else begin
                                drive_q  <= 1'b0;
                                bitCnt_q <= 3'd0;
                                if (state_q == ST_ACK_A && rw_q) begin
                                    state_q <= ST_RDATA;
                                    drive_q <= ~shift_q[7];
                                end else if (state_q == ST_ACK_A) begin
                                    state_q <= ST_REG;
                                end else begin
                                    state_q <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_REG: begin
                        if (sclRise) begin
                            shift_q <= rxByte;
                            if (bitCnt_q == 3'd7) begin
                                ptr_q    <= rxByte;
                                bitCnt_q <= 3'd0;
                                state_q  <= ST_ACK_R;
                            end else begin
                                bitCnt_q <= bitCnt_q + 3'd1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclRise) begin
                            shift_q <= rxByte;
                            if (bitCnt_q == 3'd7) begin
                                wdata_q  <= rxByte;
                                wrEn_q   <= 1'b1;
                                ptrInc_q <= 1'b1;
                                bitCnt_q <= 3'd0;
                                state_q  <= ST_ACK_W;
                            end else begin
                                bitCnt_q <= bitCnt_q + 3'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fallDly_q) begin
                            if (bitCnt_q == 3'd7) begin
                                drive_q  <= 1'b0;
                                bitCnt_q <= 3'd0;
                                state_q  <= ST_RACK;
                            end else begin
                                bitCnt_q <= bitCnt_q + 3'd1;
                                shift_q  <= {shift_q[6:0], 1'b0};
                                drive_q  <= ~shift_q[6];
                            end
                        end
                    end
                    // bitCnt_q doubles as a flag: 1 once the master has ACKed and the next byte is fetched.
                    ST_RACK: begin
                        if (sclRise && bitCnt_q == 3'd0) begin
                            if (!sdaNow) begin
                                ptr_q    <= ptr_q + 8'd1;
                                rdEn_q   <= 1'b1;
                                bitCnt_q <= 3'd1;
                            end else begin
                                state_q <= ST_WAIT;
                                busy_q  <= 1'b0;
                            end
                        end else if (fallDly_q && bitCnt_q == 3'd1) begin
                            bitCnt_q <= 3'd0;
                            state_q  <= ST_RDATA;
                            drive_q  <= ~shift_q[7];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench acting as I2C controller for i2c_slave_regif, with a transaction-level model of the
// target's register pointer and an attached register file.
`timescale 1ns/1ps
module tb_i2c_slave_regif;

    localparam logic [6:0] DEV = 7'h42;
    localparam int         Q   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sdaLow;
    wire         sdaLine;
    logic [7:0]  regAddr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        wrEn;
    logic        rdEn;
    logic        busy;

    logic [7:0]  regFile  [256];
    logic [7:0]  modelMem [256];
    logic [7:0]  modelPtr;
    logic [15:0] expWrQ [$];
    logic [7:0]  expRdQ [$];
    logic [7:0]  txData [8];
    logic [7:0]  rxData [8];
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    assign sdaLine = sdaLow ? 1'b0 : 1'bz;
    pullup (sdaLine);

    i2c_slave_regif #(.SLAVE_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .SCL        (scl),
        .SDA        (sdaLine),
        .o_reg_addr (regAddr),
        .o_wr_en    (wrEn),
        .o_wdata    (wdata),
        .o_rd_en    (rdEn),
        .i_rdata    (rdata),
        .o_busy     (busy)
    );

    // Register file behind the target; reset gives every location a known pattern.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) regFile[i] <= 8'(i) ^ 8'hA5;
        end else if (wrEn) begin
            regFile[regAddr] <= wdata;
        end
    end
    assign rdata = regFile[regAddr];

    // Every write/read strobe must match the next access the model predicted.
    always @(negedge clk) begin
        if (!rst) begin
            if (wrEn) begin
                checks++;
                if (expWrQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL spuriousWrite: got addr %02h data %02h, expected no write", regAddr, wdata);
                end else if ({regAddr, wdata} !== expWrQ[0]) begin
                    fails++;
                    $display("[TB] FAIL writeStrobe: got %04h, expected %04h", {regAddr, wdata}, expWrQ[0]);
                    void'(expWrQ.pop_front());
                end else begin
                    void'(expWrQ.pop_front());
                end
            end
            if (rdEn) begin
                checks++;
                if (expRdQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL spuriousRead: got addr %02h, expected no read", regAddr);
                end else if (regAddr !== expRdQ[0]) begin
                    fails++;
                    $display("[TB] FAIL readStrobe: got %02h, expected %02h", regAddr, expRdQ[0]);
                    void'(expRdQ.pop_front());
                end else begin
                    void'(expRdQ.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        for (int i = 0; i < 256; i++) modelMem[i] = 8'(i) ^ 8'hA5;
        modelPtr = 8'h00;
    endtask

    task automatic i2cStart();
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b0;    waitClk(Q);
    endtask

    task automatic i2cRepStart();
        sdaLow = 1'b0; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b0;    waitClk(Q);
    endtask

    task automatic i2cStop();
        sdaLow = 1'b1; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        sdaLow = 1'b0; waitClk(2 * Q);
    endtask

    task automatic sendBit(input logic b);
        sdaLow = ~b; waitClk(Q);
        scl = 1'b1;  waitClk(2 * Q);
        scl = 1'b0;  waitClk(Q);
    endtask

    task automatic recvBit(output logic b);
        sdaLow = 1'b0; waitClk(Q);
        scl = 1'b1;    waitClk(Q);
        b = sdaLine;   waitClk(Q);
        scl = 1'b0;    waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic bitIn;
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        recvBit(bitIn);
        ack = ~bitIn;
    endtask

    task automatic readByte(input logic ackIt, output logic [7:0] b);
        logic bitIn;
        for (int i = 7; i >= 0; i--) begin
            recvBit(bitIn);
            b[i] = bitIn;
        end
        sendBit(~ackIt);
    endtask

    task automatic applyWrite(input logic [6:0] dev, input logic [7:0] regA, input int n);
        logic       ack;
        logic [7:0] a;
        i2cStart();
        writeByte({dev, 1'b0}, ack);
        checkOutput("addrAck", ack, dev == DEV);
        if (dev != DEV) begin
            checkOutput("busyNoMatch", busy, 1'b0);
            i2cStop();
            waitClk(4);
            checkOutput("ptrNoMatch", regAddr, modelPtr);
            return;
        end
        checkOutput("busyAfterAddr", busy, 1'b1);
        writeByte(regA, ack);
        checkOutput("regAck", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            a = regA + 8'(i);
            expWrQ.push_back({a, txData[i]});
            modelMem[a] = txData[i];
            writeByte(txData[i], ack);
            checkOutput("dataAck", ack, 1'b1);
        end
        modelPtr = regA + 8'(n);
        i2cStop();
        waitClk(4);
        checkOutput("busyAfterStop", busy, 1'b0);
        checkOutput("ptrAfterWrite", regAddr, modelPtr);
    endtask

    task automatic applyRead(input logic [7:0] regA, input int n);
        logic       ack;
        logic [7:0] b;
        i2cStart();
        writeByte({DEV, 1'b0}, ack);
        checkOutput("rdAddrWAck", ack, 1'b1);
        writeByte(regA, ack);
        checkOutput("rdRegAck", ack, 1'b1);
        for (int i = 0; i < n; i++) expRdQ.push_back(regA + 8'(i));
        i2cRepStart();
        writeByte({DEV, 1'b1}, ack);
        checkOutput("rdAddrRAck", ack, 1'b1);
        checkOutput("busyInRead", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            readByte(i < n - 1, b);
            rxData[i] = b;
            checkOutput("readData", b, modelMem[regA + 8'(i)]);
        end
        modelPtr = regA + 8'(n - 1);
        i2cStop();
        waitClk(4);
        checkOutput("sdaFreeAfterRead", sdaLine, 1'b1);
        checkOutput("busyAfterRead", busy, 1'b0);
        checkOutput("ptrAfterRead", regAddr, modelPtr);
    endtask

    task automatic applyStimulus();
        logic       ack;
        logic [6:0] dev;
        int         kind;
        int         n;

        rst = 1'b1; scl = 1'b1; sdaLow = 1'b0;
        modelReset();
        waitClk(5);
        checkOutput("rstRegAddr", regAddr, 8'h00);
        checkOutput("rstWrEn", wrEn, 1'b0);
        checkOutput("rstRdEn", rdEn, 1'b0);
        checkOutput("rstWdata", wdata, 8'h00);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstSda", sdaLine, 1'b1);
        rst = 1'b0;
        waitClk(5);

        txData[0] = 8'h80;
        applyWrite(DEV, 8'h12, 1);
        checkOutput("litPtr13", regAddr, 8'h13);
        checkOutput("litMem12", regFile[8'h12], 8'h80);

        applyWrite(7'h43, 8'h12, 1);

        txData[0] = 8'h5A;
        applyWrite(DEV, 8'h12, 1);
        applyRead(8'h12, 1);
        checkOutput("litRead12", rxData[0], 8'h5A);

        txData[0] = 8'hFE; txData[1] = 8'hFF; txData[2] = 8'h00;
        applyWrite(DEV, 8'hFE, 3);
        checkOutput("litWrapPtr", regAddr, 8'h01);
        checkOutput("litMemFF", regFile[8'hFF], 8'hFF);

        txData[0] = 8'h11; txData[1] = 8'h22; txData[2] = 8'h33;
        applyWrite(DEV, 8'h20, 3);
        applyRead(8'h20, 3);
        checkOutput("litSeq0", rxData[0], 8'h11);
        checkOutput("litSeq1", rxData[1], 8'h22);
        checkOutput("litSeq2", rxData[2], 8'h33);
        checkOutput("litSeqPtr", regAddr, 8'h22);

        // Reset partway into a data byte: bus freed at once, no write, pointer cleared.
        i2cStart();
        writeByte({DEV, 1'b0}, ack);
        writeByte(8'h40, ack);
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b0); sendBit(1'b0);
        sdaLow = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("sdaOnReset", sdaLine, 1'b1);
        waitClk(3);
        rst = 1'b0;
        modelReset();
        waitClk(2);
        checkOutput("busyAfterReset", busy, 1'b0);
        checkOutput("ptrAfterReset", regAddr, 8'h00);
        i2cStop();
        waitClk(4);

        // STOP partway into a data byte abandons it without a write.
        i2cStart();
        writeByte({DEV, 1'b0}, ack);
        writeByte(8'h30, ack);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        i2cStop();
        waitClk(4);
        modelPtr = 8'h30;
        checkOutput("busyAfterAbort", busy, 1'b0);
        checkOutput("sdaAfterAbort", sdaLine, 1'b1);
        checkOutput("ptrAfterAbort", regAddr, 8'h30);

        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 9));
            n    = int'($urandom_range(1, 4));
            for (int i = 0; i < 8; i++) txData[i] = 8'($urandom);
            if (kind == 0) begin
                dev = 7'($urandom_range(0, 127));
                if (dev == DEV) dev = 7'h43;
                applyWrite(dev, 8'($urandom), n);
            end else if (kind < 5) begin
                applyWrite(DEV, 8'($urandom), n);
            end else begin
                applyRead(8'($urandom), n);
            end
        end

        waitClk(10);
        checkOutput("wrQueueDrained", expWrQ.size(), 0);
        checkOutput("rdQueueDrained", expRdQ.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
